cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between the two result producers: the ALU/branch unit fed by the reservation station, and the load/store buffer.
- Each producer pushes completions into a small private FIFO.
- A round-robin scheduler pops at most one entry per cycle onto a registered CDB.
- The CDB is consumed by the reorder buffer, the reservation station and the LSB. A mispredict flush discards all pending results.

Parameters:
- ROB_BIT, 5, width of ROB tag; tag 0 means "no tag"/invalid.
- DAT_W, 32, result data width.
- ADR_W, 32, branch target address width.
- QD, 4, depth of each per-source FIFO; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  global ready; when low the block freezes.
- flush_i  in  1  mispredict flush (branch flag from ROB).
- alu_vld_i  in  1  ALU result valid.
- alu_rdy_o  out  1  ALU FIFO can accept this cycle.
- alu_q_i  in  ROB_BIT  ALU result ROB tag.
- alu_v_i  in  DAT_W  ALU result value.
- alu_cbr_i  in  1  computed branch taken.
- alu_cbt_i  in  ADR_W  computed branch target.
- lsb_vld_i  in  1  load result valid.
- lsb_rdy_o  out  1  LSB FIFO can accept this cycle.
- lsb_q_i  in  ROB_BIT  load ROB tag.
- lsb_v_i  in  DAT_W  load value.
- cdb_en_o  out  1  CDB broadcast valid (one-cycle pulse per result).
- cdb_q_o  out  ROB_BIT  broadcast tag.
- cdb_v_o  out  DAT_W  broadcast value.
- cdb_cbr_o  out  1  taken flag; 0 for LSB results.
- cdb_cbt_o  out  ADR_W  branch target; 0 for LSB results.
- cdb_src_o  out  1  0 = ALU, 1 = LSB.

Behaviour:
Reset (rst low, asynchronous):
- All FIFO pointers and counts are 0; last-grant register = LSB, so ALU wins the first tie.
- cdb_en_o, cdb_q_o, cdb_v_o, cdb_cbr_o, cdb_cbt_o and cdb_src_o are all 0.

Ready and push:
- x_rdy_o = en && !flush_i && (count_x != QD). Combinational; based on the current count only, so a full FIFO does not accept even in a cycle where it pops.
- Push occurs when x_vld_i && x_rdy_o. A push with tag 0 is handshaken but not stored.

Grant (evaluated on the current FIFO heads, only when en && !flush_i):
- Only one FIFO non-empty: grant it.
- Both non-empty: grant the source opposite to the last grant, then update the last-grant register.
- Neither non-empty: no grant.

Output:
- The granted head is popped and registered onto cdb_*_o. cdb_en_o is 1 for exactly that following cycle.
- With no grant, cdb_en_o = 0 and the data outputs hold their previous values.

Latency:
- A result accepted at edge N, into an empty FIFO that wins arbitration, has cdb_en_o high after edge N+1.
- Worst case with both sources continuously busy: 2 cycles per source per result.
- Push and pop on the same FIFO in the same cycle are legal; the count is unchanged.

Ordering and wrap:
- Per-source order is FIFO. Pointers are log2(QD) bits and wrap naturally. Count is log2(QD)+1 bits.

Flush (flush_i high at an edge, en ignored):
- Both FIFOs are emptied; no push and no pop that cycle.
- cdb_en_o <= 0; last grant <= LSB.
- Data outputs are held.

en low:
- No push and no pop; last grant is held.
- cdb_en_o <= 0 at the next edge. FIFO contents are retained.

Reset during operation:
- Asynchronously clears everything, as described under Reset; in-flight results are lost.

Test Plan:
- Single ALU push (q=3, v=0x11, cbr=1, cbt=0x100) into idle block -> after the next edge cdb_en_o=1, q=3, v=0x11, cbr=1, cbt=0x100, src=0; one cycle later cdb_en_o=0.
- ALU and LSB push every cycle for 8 cycles (ALU tags 1..8, LSB tags 9..16), starting from reset -> CDB order is 1, 9, 2, 10, 3, ...; alu_rdy_o and lsb_rdy_o drop when count reaches 4; no tag is lost or duplicated.
- ALU only, 4 pushes with no LSB traffic -> 4 consecutive cdb_en_o pulses, tags in push order; then an LSB push of tag 7 is granted on the next free cycle with src=1, cbr=0, cbt=0.
- Fill both FIFOs to QD=4, then assert flush_i for one cycle -> cdb_en_o=0 the next cycle and stays 0; both rdy_o=1 afterwards; the next ALU push with tag 5 is broadcast first.
- Push with tag 0 on ALU -> handshake completes, no CDB pulse ever appears for it.
- Hold en=0 with 2 ALU entries queued for 3 cycles -> no cdb_en_o and rdy_o=0; after en=1 both entries broadcast in order. Asserting rst low asynchronously mid-stream -> cdb_en_o=0 immediately and FIFOs empty.

Source files
------------

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Shares the single common data bus (CDB) between the two result producers:
// the ALU/branch unit and the load/store buffer. Each producer pushes
// completions into a small private FIFO; a round-robin scheduler pops at most
// one head per cycle onto a registered CDB. A mispredict flush drops every
// pending result.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-low reset
//   en         global ready; when low the block freezes
//   flush_i    mispredict flush, empties both FIFOs
//   alu_*_i    ALU result: valid, ROB tag, value, branch taken, branch target
//   alu_rdy_o  ALU FIFO can accept this cycle
//   lsb_*_i    load result: valid, ROB tag, value
//   lsb_rdy_o  LSB FIFO can accept this cycle
//   cdb_en_o   one-cycle broadcast pulse per result
//   cdb_q_o    broadcast ROB tag
//   cdb_v_o    broadcast value
//   cdb_cbr_o  branch taken (0 for LSB results)
//   cdb_cbt_o  branch target (0 for LSB results)
//   cdb_src_o  0 = ALU, 1 = LSB
// -----------------------------------------------------------------------------
module cdb_arbiter #(
   parameter int unsigned ROB_BIT = 5,
   parameter int unsigned DAT_W   = 32,
   parameter int unsigned ADR_W   = 32,
   parameter int unsigned QD      = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               flush_i,

   input  logic               alu_vld_i,
   output logic               alu_rdy_o,
   input  logic [ROB_BIT-1:0] alu_q_i,
   input  logic [DAT_W-1:0]   alu_v_i,
   input  logic               alu_cbr_i,
   input  logic [ADR_W-1:0]   alu_cbt_i,

   input  logic               lsb_vld_i,
   output logic               lsb_rdy_o,
   input  logic [ROB_BIT-1:0] lsb_q_i,
   input  logic [DAT_W-1:0]   lsb_v_i,

   output logic               cdb_en_o,
   output logic [ROB_BIT-1:0] cdb_q_o,
   output logic [DAT_W-1:0]   cdb_v_o,
   output logic               cdb_cbr_o,
   output logic [ADR_W-1:0]   cdb_cbt_o,
   output logic               cdb_src_o
);

   localparam int unsigned PW = $clog2(QD);
   localparam int unsigned CW = PW + 1;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_LSB = 1'b1
   } src_e;

   // ---------------------------------------------------------------------------
   // Storage and state
   // ---------------------------------------------------------------------------
   logic [ROB_BIT-1:0] a_tag_q [QD];
   logic [DAT_W-1:0]   a_val_q [QD];
   logic               a_cbr_q [QD];
   logic [ADR_W-1:0]   a_cbt_q [QD];
   logic [ROB_BIT-1:0] l_tag_q [QD];
   logic [DAT_W-1:0]   l_val_q [QD];

   logic [PW-1:0]      a_wr_q, a_wr_d, a_rd_q, a_rd_d;
   logic [PW-1:0]      l_wr_q, l_wr_d, l_rd_q, l_rd_d;
   logic [CW-1:0]      a_cnt_q, a_cnt_d, l_cnt_q, l_cnt_d;

   src_e               last_q, last_d;

   logic               cdb_en_q, cdb_en_d;
   logic [ROB_BIT-1:0] cdb_q_q, cdb_q_d;
   logic [DAT_W-1:0]   cdb_v_q, cdb_v_d;
   logic               cdb_cbr_q, cdb_cbr_d;
   logic [ADR_W-1:0]   cdb_cbt_q, cdb_cbt_d;
   logic               cdb_src_q, cdb_src_d;

   // ---------------------------------------------------------------------------
   // Handshake
   // ---------------------------------------------------------------------------
   logic run;
   logic a_push, l_push;
   logic a_ne, l_ne;
   logic gnt_alu, gnt_lsb;

   assign run = en && !flush_i;

   // Readiness looks at the current count only: a full FIFO refuses a push
   // even in a cycle where it is being popped.
   assign alu_rdy_o = run && (a_cnt_q != CW'(QD));
   assign lsb_rdy_o = run && (l_cnt_q != CW'(QD));

   // Tag 0 means "no result": the handshake completes but nothing is stored.
   assign a_push = alu_vld_i && alu_rdy_o && (alu_q_i != '0);
   assign l_push = lsb_vld_i && lsb_rdy_o && (lsb_q_i != '0);

   assign a_ne = (a_cnt_q != '0);
   assign l_ne = (l_cnt_q != '0);

   // ---------------------------------------------------------------------------
   // Grant: the last-grant register only moves when both heads compete.
   // ---------------------------------------------------------------------------
   always_comb begin
      gnt_alu = 1'b0;
      gnt_lsb = 1'b0;
      last_d  = last_q;
      if (flush_i) begin
         last_d = SRC_LSB;
      end else if (run) begin
         if (a_ne && l_ne) begin
            if (last_q == SRC_LSB) begin
               gnt_alu = 1'b1;
               last_d  = SRC_ALU;
            end else begin
               gnt_lsb = 1'b1;
               last_d  = SRC_LSB;
            end
         end else if (a_ne) begin
            gnt_alu = 1'b1;
         end else if (l_ne) begin
            gnt_lsb = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // FIFO pointer / count next state
   // ---------------------------------------------------------------------------
   always_comb begin
      a_wr_d  = a_wr_q;
      a_rd_d  = a_rd_q;
      a_cnt_d = a_cnt_q;
      l_wr_d  = l_wr_q;
      l_rd_d  = l_rd_q;
      l_cnt_d = l_cnt_q;
      if (flush_i) begin
         a_wr_d  = '0;
         a_rd_d  = '0;
         a_cnt_d = '0;
         l_wr_d  = '0;
         l_rd_d  = '0;
         l_cnt_d = '0;
      end else begin
         if (a_push)  a_wr_d = a_wr_q + PW'(1);
         if (gnt_alu) a_rd_d = a_rd_q + PW'(1);
         if (l_push)  l_wr_d = l_wr_q + PW'(1);
         if (gnt_lsb) l_rd_d = l_rd_q + PW'(1);
         a_cnt_d = a_cnt_q + CW'(a_push) - CW'(gnt_alu);
         l_cnt_d = l_cnt_q + CW'(l_push) - CW'(gnt_lsb);
      end
   end

   // ---------------------------------------------------------------------------
   // CDB next state: data fields hold when nothing is granted.
   // ---------------------------------------------------------------------------
   always_comb begin
      cdb_en_d  = gnt_alu || gnt_lsb;
      cdb_q_d   = cdb_q_q;
      cdb_v_d   = cdb_v_q;
      cdb_cbr_d = cdb_cbr_q;
      cdb_cbt_d = cdb_cbt_q;
      cdb_src_d = cdb_src_q;
      if (gnt_alu) begin
         cdb_q_d   = a_tag_q[a_rd_q];
         cdb_v_d   = a_val_q[a_rd_q];
         cdb_cbr_d = a_cbr_q[a_rd_q];
         cdb_cbt_d = a_cbt_q[a_rd_q];
         cdb_src_d = SRC_ALU;
      end else if (gnt_lsb) begin
         cdb_q_d   = l_tag_q[l_rd_q];
         cdb_v_d   = l_val_q[l_rd_q];
         cdb_cbr_d = 1'b0;
         cdb_cbt_d = '0;
         cdb_src_d = SRC_LSB;
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_wr_q    <= '0;
         a_rd_q    <= '0;
         a_cnt_q   <= '0;
         l_wr_q    <= '0;
         l_rd_q    <= '0;
         l_cnt_q   <= '0;
         last_q    <= SRC_LSB;
         cdb_en_q  <= 1'b0;
         cdb_q_q   <= '0;
         cdb_v_q   <= '0;
         cdb_cbr_q <= 1'b0;
         cdb_cbt_q <= '0;
         cdb_src_q <= 1'b0;
      end else begin
         a_wr_q    <= a_wr_d;
         a_rd_q    <= a_rd_d;
         a_cnt_q   <= a_cnt_d;
         l_wr_q    <= l_wr_d;
         l_rd_q    <= l_rd_d;
         l_cnt_q   <= l_cnt_d;
         last_q    <= last_d;
         cdb_en_q  <= cdb_en_d;
         cdb_q_q   <= cdb_q_d;
         cdb_v_q   <= cdb_v_d;
         cdb_cbr_q <= cdb_cbr_d;
         cdb_cbt_q <= cdb_cbt_d;
         cdb_src_q <= cdb_src_d;
      end
   end

   // Entry storage is only ever read behind a non-zero count, so it needs no reset.
   always_ff @(posedge clk) begin
      if (a_push) begin
         a_tag_q[a_wr_q] <= alu_q_i;
         a_val_q[a_wr_q] <= alu_v_i;
         a_cbr_q[a_wr_q] <= alu_cbr_i;
         a_cbt_q[a_wr_q] <= alu_cbt_i;
      end
      if (l_push) begin
         l_tag_q[l_wr_q] <= lsb_q_i;
         l_val_q[l_wr_q] <= lsb_v_i;
      end
   end

   assign cdb_en_o  = cdb_en_q;
   assign cdb_q_o   = cdb_q_q;
   assign cdb_v_o   = cdb_v_q;
   assign cdb_cbr_o = cdb_cbr_q;
   assign cdb_cbt_o = cdb_cbt_q;
   assign cdb_src_o = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Directed scenarios plus a randomized run. A queue-based model of the two
// FIFOs and the round-robin rule predicts ready, and the registered CDB, on
// every cycle; literal expectations pin the model in the directed scenarios.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

   localparam int unsigned ROB_BIT = 5;
   localparam int unsigned DAT_W   = 32;
   localparam int unsigned ADR_W   = 32;
   localparam int unsigned QD      = 4;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               en = 1'b1;
   logic               flush_i = 1'b0;
   logic               alu_vld_i = 1'b0;
   logic               alu_rdy_o;
   logic [ROB_BIT-1:0] alu_q_i = '0;
   logic [DAT_W-1:0]   alu_v_i = '0;
   logic               alu_cbr_i = 1'b0;
   logic [ADR_W-1:0]   alu_cbt_i = '0;
   logic               lsb_vld_i = 1'b0;
   logic               lsb_rdy_o;
   logic [ROB_BIT-1:0] lsb_q_i = '0;
   logic [DAT_W-1:0]   lsb_v_i = '0;
   logic               cdb_en_o;
   logic [ROB_BIT-1:0] cdb_q_o;
   logic [DAT_W-1:0]   cdb_v_o;
   logic               cdb_cbr_o;
   logic [ADR_W-1:0]   cdb_cbt_o;
   logic               cdb_src_o;

   cdb_arbiter #(
      .ROB_BIT(ROB_BIT),
      .DAT_W  (DAT_W),
      .ADR_W  (ADR_W),
      .QD     (QD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .flush_i   (flush_i),
      .alu_vld_i (alu_vld_i),
      .alu_rdy_o (alu_rdy_o),
      .alu_q_i   (alu_q_i),
      .alu_v_i   (alu_v_i),
      .alu_cbr_i (alu_cbr_i),
      .alu_cbt_i (alu_cbt_i),
      .lsb_vld_i (lsb_vld_i),
      .lsb_rdy_o (lsb_rdy_o),
      .lsb_q_i   (lsb_q_i),
      .lsb_v_i   (lsb_v_i),
      .cdb_en_o  (cdb_en_o),
      .cdb_q_o   (cdb_q_o),
      .cdb_v_o   (cdb_v_o),
      .cdb_cbr_o (cdb_cbr_o),
      .cdb_cbt_o (cdb_cbt_o),
      .cdb_src_o (cdb_src_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ROB_BIT-1:0] q;
      logic [DAT_W-1:0]   v;
      logic               cbr;
      logic [ADR_W-1:0]   cbt;
   } ent_t;

   // model state
   ent_t               ma[$];
   ent_t               ml[$];
   bit                 m_last_lsb;
   bit                 e_en;
   logic [ROB_BIT-1:0] e_q;
   logic [DAT_W-1:0]   e_v;
   bit                 e_cbr;
   logic [ADR_W-1:0]   e_cbt;
   bit                 e_src;

   int                 n_vec = 0;
   int                 n_err = 0;
   logic [ROB_BIT-1:0] seen[$];
   bit                 hs_a, hs_l, dut_ardy, dut_lrdy;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      ma.delete();
      ml.delete();
      m_last_lsb = 1'b1;
      e_en  = 1'b0;
      e_q   = '0;
      e_v   = '0;
      e_cbr = 1'b0;
      e_cbt = '0;
      e_src = 1'b0;
   endtask

   task automatic idle();
      alu_vld_i = 1'b0;
      lsb_vld_i = 1'b0;
   endtask

   task automatic drv_alu(input int q, input int v, input bit cbr, input int cbt);
      alu_vld_i = 1'b1;
      alu_q_i   = ROB_BIT'(q);
      alu_v_i   = DAT_W'(v);
      alu_cbr_i = cbr;
      alu_cbt_i = ADR_W'(cbt);
   endtask

   task automatic drv_lsb(input int q, input int v);
      lsb_vld_i = 1'b1;
      lsb_q_i   = ROB_BIT'(q);
      lsb_v_i   = DAT_W'(v);
   endtask

   // One clock: check ready, advance model across the edge, check the CDB.
   task automatic cycle();
      bit   run, ra, rl, pa, pl, both;
      ent_t ea, el, g;
      #1;
      run = en && !flush_i;
      ra  = run && (ma.size() != QD);
      rl  = run && (ml.size() != QD);
      dut_ardy = alu_rdy_o;
      dut_lrdy = lsb_rdy_o;
      chk("alu_rdy", {63'd0, alu_rdy_o}, {63'd0, ra});
      chk("lsb_rdy", {63'd0, lsb_rdy_o}, {63'd0, rl});
      hs_a = alu_vld_i && ra;
      hs_l = lsb_vld_i && rl;
      pa   = hs_a && (alu_q_i != 0);
      pl   = hs_l && (lsb_q_i != 0);
      ea   = '{q: alu_q_i, v: alu_v_i, cbr: alu_cbr_i, cbt: alu_cbt_i};
      el   = '{q: lsb_q_i, v: lsb_v_i, cbr: 1'b0, cbt: '0};
      @(posedge clk);
      if (flush_i) begin
         ma.delete();
         ml.delete();
         e_en = 1'b0;
         m_last_lsb = 1'b1;
      end else if (!en) begin
         e_en = 1'b0;
      end else begin
         both = (ma.size() > 0) && (ml.size() > 0);
         e_en = 1'b0;
         if (both ? m_last_lsb : (ma.size() > 0)) begin
            g = ma.pop_front();
            e_en = 1'b1; e_src = 1'b0;
            e_q = g.q; e_v = g.v; e_cbr = g.cbr; e_cbt = g.cbt;
            if (both) m_last_lsb = 1'b0;
         end else if (ml.size() > 0) begin
            g = ml.pop_front();
            e_en = 1'b1; e_src = 1'b1;
            e_q = g.q; e_v = g.v; e_cbr = 1'b0; e_cbt = '0;
            if (both) m_last_lsb = 1'b1;
         end
         if (pa) ma.push_back(ea);
         if (pl) ml.push_back(el);
      end
      #1;
      chk("cdb_en",  {63'd0, cdb_en_o},  {63'd0, e_en});
      chk("cdb_q",   64'(cdb_q_o),       64'(e_q));
      chk("cdb_v",   64'(cdb_v_o),       64'(e_v));
      chk("cdb_cbr", {63'd0, cdb_cbr_o}, {63'd0, e_cbr});
      chk("cdb_cbt", 64'(cdb_cbt_o),     64'(e_cbt));
      chk("cdb_src", {63'd0, cdb_src_o}, {63'd0, e_src});
      if (cdb_en_o) seen.push_back(cdb_q_o);
   endtask

   // Asynchronous reset applied between edges; outputs must clear at once.
   task automatic hw_reset();
      idle();
      en      = 1'b1;
      flush_i = 1'b0;
      rst     = 1'b0;
      #2;
      chk("rst_cdb_en",  {63'd0, cdb_en_o}, 64'd0);
      chk("rst_cdb_q",   64'(cdb_q_o),      64'd0);
      chk("rst_cdb_v",   64'(cdb_v_o),      64'd0);
      chk("rst_cdb_src", {63'd0, cdb_src_o}, 64'd0);
      chk("rst_alu_rdy", {63'd0, alu_rdy_o}, 64'd1);
      chk("rst_lsb_rdy", {63'd0, lsb_rdy_o}, 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      seen.delete();
   endtask

   initial begin
      int na, nl, c;
      bit saw_a_full, saw_l_full;
      model_reset();
      #1;

      // T1: single ALU result
      hw_reset();
      cycle();
      drv_alu(3, 'h11, 1'b1, 'h100);
      cycle();
      idle();
      cycle();
      chk("t1_en",  {63'd0, cdb_en_o},  64'd1);
      chk("t1_q",   64'(cdb_q_o),       64'd3);
      chk("t1_v",   64'(cdb_v_o),       64'h11);
      chk("t1_cbr", {63'd0, cdb_cbr_o}, 64'd1);
      chk("t1_cbt", 64'(cdb_cbt_o),     64'h100);
      chk("t1_src", {63'd0, cdb_src_o}, 64'd0);
      cycle();
      chk("t1_en_drop", {63'd0, cdb_en_o}, 64'd0);

      // T2: both sources busy, tags 1..8 and 9..16
      hw_reset();
      na = 1; nl = 9; saw_a_full = 0; saw_l_full = 0;
      for (int i = 0; i < 40; i++) begin
         if (na <= 8) drv_alu(na, na * 7, 1'b0, na); else alu_vld_i = 1'b0;
         if (nl <= 16) drv_lsb(nl, nl * 5); else lsb_vld_i = 1'b0;
         cycle();
         if (hs_a) na++;
         if (hs_l) nl++;
         if (!dut_ardy) saw_a_full = 1;
         if (!dut_lrdy) saw_l_full = 1;
      end
      idle();
      chk("t2_count", 64'(seen.size()), 64'd16);
      for (int i = 0; i < 16 && i < seen.size(); i++)
         chk("t2_order", 64'(seen[i]), 64'((i % 2 == 0) ? (i / 2 + 1) : (i / 2 + 9)));
      chk("t2_alu_full", {63'd0, saw_a_full}, 64'd1);
      chk("t2_lsb_full", {63'd0, saw_l_full}, 64'd1);

      // T3: ALU-only burst, then an LSB result
      hw_reset();
      for (int t = 1; t <= 4; t++) begin
         drv_alu(t, t + 'h40, 1'b1, t + 'h200);
         cycle();
      end
      idle();
      drv_lsb(7, 'h77);
      cycle();
      idle();
      cycle();
      chk("t3_en",  {63'd0, cdb_en_o},  64'd1);
      chk("t3_q",   64'(cdb_q_o),       64'd7);
      chk("t3_v",   64'(cdb_v_o),       64'h77);
      chk("t3_src", {63'd0, cdb_src_o}, 64'd1);
      chk("t3_cbr", {63'd0, cdb_cbr_o}, 64'd0);
      chk("t3_cbt", 64'(cdb_cbt_o),     64'd0);
      chk("t3_count", 64'(seen.size()), 64'd5);
      for (int i = 0; i < 5 && i < seen.size(); i++)
         chk("t3_order", 64'(seen[i]), 64'((i < 4) ? i + 1 : 7));

      // T4: fill, then flush
      hw_reset();
      c = 0;
      while ((ma.size() + ml.size() < 7) && c < 40) begin
         drv_alu(1 + (c % 31), c, 1'b0, 0);
         drv_lsb(1 + ((c + 11) % 31), c);
         cycle();
         c++;
      end
      chk("t4_filled", 64'(ma.size() + ml.size() >= 7), 64'd1);
      idle();
      flush_i = 1'b1;
      cycle();
      flush_i = 1'b0;
      #1;
      chk("t4_en_after_flush", {63'd0, cdb_en_o},  64'd0);
      chk("t4_alu_rdy",        {63'd0, alu_rdy_o}, 64'd1);
      chk("t4_lsb_rdy",        {63'd0, lsb_rdy_o}, 64'd1);
      cycle();
      cycle();
      chk("t4_en_stays_low", {63'd0, cdb_en_o}, 64'd0);
      seen.delete();
      drv_alu(5, 'h55, 1'b0, 'h500);
      cycle();
      idle();
      cycle();
      cycle();
      chk("t4_count", 64'(seen.size()), 64'd1);
      if (seen.size() > 0) chk("t4_first", 64'(seen[0]), 64'd5);

      // T5: tag 0 is accepted but never broadcast
      hw_reset();
      drv_alu(0, 'h99, 1'b1, 'h44);
      cycle();
      chk("t5_handshake", {63'd0, dut_ardy}, 64'd1);
      idle();
      for (int i = 0; i < 4; i++) cycle();
      chk("t5_no_pulse", 64'(seen.size()), 64'd0);

      // T6: freeze with two ALU entries queued
      hw_reset();
      drv_alu(21, 'h21, 1'b0, 0); drv_lsb(30, 'h30);
      cycle();
      drv_alu(22, 'h22, 1'b1, 'h22); drv_lsb(31, 'h31);
      cycle();
      idle();
      drv_alu(23, 'h23, 1'b0, 'h23);
      cycle();
      idle();
      en = 1'b0;
      seen.delete();
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("t6_frozen_en",  {63'd0, cdb_en_o},  64'd0);
         chk("t6_frozen_rdy", {63'd0, alu_rdy_o}, 64'd0);
      end
      en = 1'b1;
      for (int i = 0; i < 4; i++) cycle();
      chk("t6_count", 64'(seen.size()), 64'd3);
      if (seen.size() == 3) begin
         chk("t6_order0", 64'(seen[0]), 64'd22);
         chk("t6_order1", 64'(seen[1]), 64'd31);
         chk("t6_order2", 64'(seen[2]), 64'd23);
      end

      // T7: async reset mid-stream with a pulse on the bus and entries queued
      drv_alu(9, 'h9, 1'b0, 0); drv_lsb(10, 'ha);
      cycle();
      cycle();
      chk("t7_pulse_before", {63'd0, cdb_en_o}, 64'd1);
      hw_reset();
      for (int i = 0; i < 3; i++) cycle();
      chk("t7_nothing_after", 64'(seen.size()), 64'd0);

      // T8: randomized traffic
      for (int i = 0; i < 1500; i++) begin
         en      = ($urandom_range(0, 9) != 0);
         flush_i = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 9) < 6)
            drv_alu($urandom_range(0, 31), $urandom, 1'($urandom), $urandom);
         else
            alu_vld_i = 1'b0;
         if ($urandom_range(0, 9) < 6)
            drv_lsb($urandom_range(0, 31), $urandom);
         else
            lsb_vld_i = 1'b0;
         cycle();
         if ($urandom_range(0, 299) == 0) hw_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
